wishbone_arbiter: RTL
=====================

# wishbone_arbiter

Shares one Wishbone classic peripheral port between several controllers, such as the SPI bridge and a future UART or debug bridge. Every controller then reaches the single `mWishboneInterconnect` and its peripherals (charlieplex, RGB). Arbitration is round-robin and happens per bus cycle (per `cyc` assertion). A watchdog aborts any transfer the peripheral side never acknowledges, so one dead peripheral cannot hang every controller.

## Interface
- `nCtrl`, default 2: number of controllers. Range 2..8.
- `nAdrBits`, default 4: address width.
- `nDatBits`, default 8: data width.
- `nTimeout`, default 255: cycles `stb` may wait for `ack` before the transfer is aborted. Must be at least 1.

Ports. One clock; reset is synchronous and active-high. The ports are `clk` and `rst`.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `ctrl_cyc` in [nCtrl]: per-controller bus-cycle request.
- `ctrl_stb` in [nCtrl]: per-controller strobe.
- `ctrl_we` in [nCtrl]: per-controller write enable.
- `ctrl_adr` in [nCtrl][nAdrBits]: per-controller address.
- `ctrl_dat_w` in [nCtrl][nDatBits]: per-controller write data.
- `ctrl_dat_r` out nDatBits: read data, broadcast to all controllers.
- `ctrl_ack` out [nCtrl]: acknowledge, routed to the granted controller only.
- `ctrl_err` out [nCtrl]: one-cycle timeout error, to the granted controller only.
- `periph_cyc`, `periph_stb`, `periph_we` out 1: toward the interconnect.
- `periph_adr` out nAdrBits: toward the interconnect.
- `periph_dat_w` out nDatBits: toward the interconnect.
- `periph_dat_r` in nDatBits: from the interconnect.
- `periph_ack` in 1: from the interconnect.
- `grant` out [nCtrl]: one-hot owner, all zero when idle. Status only.

## Operation
- State machine with three states: IDLE, BUSY, FLUSH.
- **IDLE**
  - All `periph_*` outputs and all `ctrl_ack`/`ctrl_err` are 0.
  - If any `ctrl_cyc` is high, select the first requester scanning upward from `last+1`, wrapping modulo nCtrl.
  - Register it into `grant` and move to BUSY.
- **BUSY** (granted controller g)
  - `periph_cyc/stb/we/adr/dat_w` combinationally mirror controller g.
  - `ctrl_ack[g] = periph_ack`. Every other controller's `ack` stays 0.
  - `ctrl_dat_r = periph_dat_r` at all times.
- **Watchdog** (active in BUSY)
  - Counter of width ceil(log2(nTimeout+1)).
  - Clears on `periph_ack`, on `ctrl_stb[g]` low, and on entry to BUSY.
  - Otherwise increments while `ctrl_stb[g]` is high.
- **Timeout**: when the counter equals nTimeout with no `ack` that cycle:
  - `ctrl_err[g]` pulses for exactly that cycle.
  - Next state is FLUSH.
- **Release**: `ctrl_cyc[g]` low in BUSY means `last <= g`, `grant <= 0`, next state IDLE.
- **FLUSH**
  - `periph_cyc` and `periph_stb` are forced to 0.
  - `ack` and `err` are suppressed.
  - Stay until `ctrl_cyc[g]` is low, then `last <= g` and go to IDLE.
- **Boundary cases**
  - `ack` and timeout in the same cycle: `ack` wins, no `err`, counter clears.
  - `periph_ack` seen in IDLE or FLUSH is ignored, never forwarded.
  - Requests from non-granted controllers wait, with `ack` held 0. They are never dropped.
  - A lone requester is re-granted repeatedly, with one IDLE cycle between grants.
  - `cyc` high with `stb` low in BUSY holds the grant. This is used for locked multi-beat sequences. The watchdog does not count.

## Timing
- **Reset values**: state IDLE, `grant` 0, `last` = nCtrl-1 (so controller 0 wins first), counter 0. All outputs are 0 from the cycle after `rst` is sampled high.
- **Reset during BUSY**: the peripheral side sees `cyc` drop the next cycle. No `ack` or `err` is issued.
- **Grant latency**: `ctrl_cyc` rising in cycle N (IDLE) gives `grant` and `periph_cyc` high in N+1.
- **Forward path**: controller to peripheral is combinational within the cycle; `ack` is returned the same cycle. There is no added pipeline latency while granted.
- **Handover**: owner drops `cyc` in cycle M; IDLE in M+1; next grant visible in M+2.
- **Timeout**: with `stb` high from cycle S and no `ack`, `err` asserts in cycle S+nTimeout and FLUSH begins at S+nTimeout+1.

## Structure
- Package `wishbone_arbiter_pkg` holds:
  - the `arb_state_t` enum (IDLE, BUSY, FLUSH);
  - a `clog2`-based width helper for the `grant` index and the watchdog counter.
- Sub-module `rr_picker` is combinational:
  - inputs: request vector and `last` index;
  - outputs: one-hot winner and index.
  - It is reusable by later schedulers.
- `grant` is stored as an index register. The one-hot `grant` output is decoded from it.

## Test plan
- **Single controller write**: ctrl0 `cyc/stb/we`=1, `adr`=3, `dat_w`=0x5A. Require `periph_*` to mirror it from N+1, and one `ack` pulse to return on `ctrl_ack[0]` only.
- **Simultaneous request**: ctrl0 and ctrl1 raise `cyc` in the same cycle after reset. Require ctrl0 granted first, ctrl1 granted 2 cycles after ctrl0 releases, then ctrl0 again on the next contention.
- **Timeout**: nTimeout=4, peripheral never acks. Require `ctrl_err[g]` high exactly 4 cycles after `stb` rises, then `periph_cyc` 0 until `ctrl_cyc` drops, and no `ack` to anyone.
- **Ack on the timeout cycle**: `ack` arrives on the nTimeout-th cycle. Require `ack` forwarded, no `err`, state stays BUSY.
- **Reset mid-transfer**: assert `rst` in BUSY. Require `periph_cyc`=0 and `grant`=0 next cycle, and ctrl0 to have priority afterward.
- **Stray ack**: `periph_ack` pulses while IDLE. Require all `ctrl_ack` to stay 0.

Source files
------------

// File: rtl/wishbone_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_arbiter_pkg
// Description : Shared types and width helpers for the Wishbone arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wishbone_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

    // Bits needed to hold the values 0 .. n_values-1, never less than one.
    function automatic int width_for(input int n_values);
        return (n_values > 2) ? $clog2(n_values) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wishbone_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_arbiter_if
// Description : Controller-side and peripheral-side Wishbone classic bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface wishbone_arbiter_if #(
    parameter int nCtrl    = 2,
    parameter int nAdrBits = 4,
    parameter int nDatBits = 8
);
    logic [nCtrl-1:0]                ctrl_cyc;
    logic [nCtrl-1:0]                ctrl_stb;
    logic [nCtrl-1:0]                ctrl_we;
    logic [nCtrl-1:0][nAdrBits-1:0]  ctrl_adr;
    logic [nCtrl-1:0][nDatBits-1:0]  ctrl_dat_w;
    logic [nDatBits-1:0]             ctrl_dat_r;
    logic [nCtrl-1:0]                ctrl_ack;
    logic [nCtrl-1:0]                ctrl_err;

    logic                            periph_cyc;
    logic                            periph_stb;
    logic                            periph_we;
    logic [nAdrBits-1:0]             periph_adr;
    logic [nDatBits-1:0]             periph_dat_w;
    logic [nDatBits-1:0]             periph_dat_r;
    logic                            periph_ack;

    logic [nCtrl-1:0]                grant;

    // Environment side: the controllers and the interconnect.
    modport master (
        output ctrl_cyc, ctrl_stb, ctrl_we, ctrl_adr, ctrl_dat_w,
        input  ctrl_dat_r, ctrl_ack, ctrl_err,
        input  periph_cyc, periph_stb, periph_we, periph_adr, periph_dat_w,
        output periph_dat_r, periph_ack,
        input  grant
    );

    // Arbiter side.
    modport slave (
        input  ctrl_cyc, ctrl_stb, ctrl_we, ctrl_adr, ctrl_dat_w,
        output ctrl_dat_r, ctrl_ack, ctrl_err,
        output periph_cyc, periph_stb, periph_we, periph_adr, periph_dat_w,
        input  periph_dat_r, periph_ack,
        output grant
    );
endinterface
`default_nettype wire

// File: rtl/wishbone_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker; first requester above last.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  wire logic [N-1:0]  req,
    input  wire logic [IW-1:0] last,
    output logic      [N-1:0]  winner_onehot,
    output logic      [IW-1:0] winner_idx
);
    int            w_cand;
    logic [IW-1:0] w_cand_idx;
    logic          w_found;

    always_comb begin
        winner_onehot = '0;
        winner_idx    = '0;
        w_cand        = 0;
        w_cand_idx    = '0;
        w_found       = 1'b0;
        for (int i = 1; i <= N; i++) begin
            w_cand     = (int'(last) + i) % N;
            w_cand_idx = IW'(w_cand);
            if (!w_found && req[w_cand_idx]) begin
                w_found                   = 1'b1;
                winner_idx                = w_cand_idx;
                winner_onehot[w_cand_idx] = 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/wishbone_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wishbone_arbiter
// Description : Round-robin Wishbone classic arbiter with an ack watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module wishbone_arbiter
    import wishbone_arbiter_pkg::*;
#(
    parameter int nCtrl    = 2,
    parameter int nAdrBits = 4,
    parameter int nDatBits = 8,
    parameter int nTimeout = 255
) (
    input  wire logic          clk,
    input  wire logic          rst,
    wishbone_arbiter_if.slave  bus
);
    localparam int IDX_W = width_for(nCtrl);
    localparam int CNT_W = width_for(nTimeout + 1);

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_gnt;
    logic [IDX_W-1:0] r_last;
    logic [CNT_W-1:0] r_cnt;

    logic [nCtrl-1:0] w_pick_oh;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_own_cyc;
    logic             w_own_stb;
    logic             w_timeout;

    rr_picker #(
        .N  (nCtrl),
        .IW (IDX_W)
    ) u_picker (
        .req           (bus.ctrl_cyc),
        .last          (r_last),
        .winner_onehot (w_pick_oh),
        .winner_idx    (w_pick_idx)
    );

    assign w_own_cyc = bus.ctrl_cyc[r_gnt];
    assign w_own_stb = bus.ctrl_stb[r_gnt];
    // An ack arriving on the expiry cycle rescues the transfer.
    assign w_timeout = (r_state == BUSY) && !bus.periph_ack && (r_cnt == CNT_W'(nTimeout));

    always_comb begin
        bus.periph_cyc   = 1'b0;
        bus.periph_stb   = 1'b0;
        bus.periph_we    = 1'b0;
        bus.periph_adr   = '0;
        bus.periph_dat_w = '0;
        bus.ctrl_ack     = '0;
        bus.ctrl_err     = '0;
        bus.ctrl_dat_r   = bus.periph_dat_r;
        bus.grant        = '0;
        if (r_state != IDLE) begin
            bus.grant[r_gnt] = 1'b1;
        end
        if (r_state == BUSY) begin
            bus.periph_cyc   = w_own_cyc;
            bus.periph_stb   = w_own_stb;
            bus.periph_we    = bus.ctrl_we[r_gnt];
            bus.periph_adr   = bus.ctrl_adr[r_gnt];
            bus.periph_dat_w = bus.ctrl_dat_w[r_gnt];
            // A reset landing mid-transfer must not complete or fail it.
            if (!rst) begin
                bus.ctrl_ack[r_gnt] = bus.periph_ack;
                bus.ctrl_err[r_gnt] = w_timeout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= IDX_W'(nCtrl - 1);
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (|w_pick_oh) begin
                        r_gnt   <= w_pick_idx;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.periph_ack || !w_own_stb) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    if (!w_own_cyc) begin
                        r_last  <= r_gnt;
                        r_state <= IDLE;
                    end else if (w_timeout) begin
                        r_state <= FLUSH;
                    end
                end
                FLUSH: begin
                    r_cnt <= '0;
                    if (!w_own_cyc) begin
                        r_last  <= r_gnt;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire
